// File: rtl/change_dispenser_pkg.sv
// Shared coin/state encodings and coin-selection helper for the change dispenser.
package vm_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10,
        ERR   = 2'b11
    } chg_state_t;

    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;

    // Largest available coin not exceeding the amount owed; NONE means stock-out.
    function automatic coin_t pick_coin(input logic ge_ten, input logic ten_ok, input logic five_ok);
        if (ge_ten && ten_ok) begin
            return COIN_10;
        end else if (five_ok) begin
            return COIN_5;
        end else begin
            return COIN_NONE;
        end
    endfunction

endpackage

// File: rtl/change_dispenser_ack_timer.sv
// Counts consecutive unacknowledged coin cycles; expired flags the ACK_TIMEOUT-th one.
module change_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] count_r;

    assign expired = enable && (count_r == TW'(ACK_TIMEOUT - 1));

    // Wait counter, restarted on every acknowledge or when no coin is shown.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clear || expired) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Refund payout FSM issuing 10/5 coins to the hopper. Optional finite coin stock
// is enabled by defining CHANGE_STOCK_EN.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 16
`ifdef CHANGE_STOCK_EN
    ,
    parameter int STOCK_W     = 6,
    parameter int TEN_INIT    = 20,
    parameter int FIVE_INIT   = 20
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AMT_W-1:0] remaining,
    input  logic             stock_refill,
    output logic             ten_empty,
    output logic             five_empty
);

    chg_state_t       state_r, state_s;
    coin_t            coin_s;
    logic [AMT_W-1:0] rem_s;
    logic [AMT_W-1:0] coin_val_s;
    logic             acked_s;
    logic             expired_s;
    logic             ten_ok_s;
    logic             five_ok_s;

    assign acked_s    = coin_valid && coin_ack;
    assign coin_val_s = (coin_out == COIN_10) ? AMT_W'(VAL_10) : AMT_W'(VAL_5);

    change_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!coin_valid || coin_ack),
        .enable  (coin_valid && !coin_ack),
        .expired (expired_s)
    );

`ifdef CHANGE_STOCK_EN
    logic [STOCK_W-1:0] ten_stock_r, five_stock_r;
    logic [STOCK_W-1:0] ten_nxt_s, five_nxt_s;
    logic               ten_dec_s, five_dec_s;

    assign ten_dec_s  = acked_s && (coin_out == COIN_10);
    assign five_dec_s = acked_s && (coin_out == COIN_5);
    // Availability is judged on the stock left after the coin being acked now.
    assign ten_ok_s   = ten_stock_r > STOCK_W'(ten_dec_s);
    assign five_ok_s  = five_stock_r > STOCK_W'(five_dec_s);

    // Next stock: refill only while idle, otherwise consume acked coins.
    always_comb begin
        ten_nxt_s  = ten_stock_r;
        five_nxt_s = five_stock_r;
        if ((state_r == IDLE) && stock_refill) begin
            ten_nxt_s  = STOCK_W'(TEN_INIT);
            five_nxt_s = STOCK_W'(FIVE_INIT);
        end else begin
            ten_nxt_s  = ten_stock_r - STOCK_W'(ten_dec_s);
            five_nxt_s = five_stock_r - STOCK_W'(five_dec_s);
        end
    end

    // Stock counters and their registered empty flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ten_stock_r  <= STOCK_W'(TEN_INIT);
            five_stock_r <= STOCK_W'(FIVE_INIT);
            ten_empty    <= (TEN_INIT == 0);
            five_empty   <= (FIVE_INIT == 0);
        end else begin
            ten_stock_r  <= ten_nxt_s;
            five_stock_r <= five_nxt_s;
            ten_empty    <= (ten_nxt_s == '0);
            five_empty   <= (five_nxt_s == '0);
        end
    end
`else
    logic stock_refill_unused;

    assign stock_refill_unused = stock_refill;
    assign ten_ok_s   = 1'b1;
    assign five_ok_s  = 1'b1;
    assign ten_empty  = 1'b0;
    assign five_empty = 1'b0;
`endif

    // Next state, amount still owed and the coin to present next cycle.
    always_comb begin
        state_s = state_r;
        rem_s   = remaining;
        coin_s  = COIN_NONE;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    rem_s = req_amount;
                    if ((req_amount % AMT_W'(VAL_5)) != '0) begin
                        state_s = ERR;
                    end else if (req_amount == '0) begin
                        state_s = DONE;
                    end else begin
                        coin_s  = pick_coin(req_amount >= AMT_W'(VAL_10), ten_ok_s, five_ok_s);
                        state_s = (coin_s == COIN_NONE) ? ERR : ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (acked_s) begin
                    rem_s = remaining - coin_val_s;
                    if (rem_s == '0) begin
                        state_s = DONE;
                    end else begin
                        coin_s  = pick_coin(rem_s >= AMT_W'(VAL_10), ten_ok_s, five_ok_s);
                        state_s = (coin_s == COIN_NONE) ? ERR : ISSUE;
                    end
                end else if (expired_s) begin
                    state_s = ERR;
                end else begin
                    coin_s  = coin_t'(coin_out);
                    state_s = ISSUE;
                end
            end
            DONE:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and all outputs registered from the next-state decision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            req_ready  <= 1'b1;
            coin_out   <= COIN_NONE;
            coin_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            remaining  <= '0;
        end else begin
            state_r    <= state_s;
            req_ready  <= (state_s == IDLE);
            coin_out   <= (state_s == ISSUE) ? coin_s : COIN_NONE;
            coin_valid <= (state_s == ISSUE);
            busy       <= (state_s == ISSUE);
            done       <= (state_s == DONE);
            error      <= (state_s == ERR);
            remaining  <= rem_s;
        end
    end

endmodule
